// File: rtl/byteswap_unpack_64.sv
// byteswap_unpack_64
// Unpacks a 64-bit host word into four 16-bit codec samples, lane 0
// (bits [15:0]) first, with optional byte swap inside each 16-bit lane.
// Optional feature: define BYTESWAP_UNPACK_SAMPLE_COUNT_EN to add the
// 32-bit sample_count output and its counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | no word held; s_axis_tready=1, m_axis_tvalid=0
// HOLD  | word held; lane (0..3) is the sample on m_axis_tdata
module byteswap_unpack_64 (
  input  logic        aclk,
  input  logic        areset,
  input  logic        swap,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
  input  logic        m_axis_tready,
  output logic [31:0] sample_count
`else
  input  logic        m_axis_tready
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  lane;
  logic [63:0] hold_reg;
  logic [63:0] load_word;
  logic [1:0]  next_lane;
  logic [15:0] next_sample;
  logic        s_xfer;
  logic        m_xfer;

  // Byte order of the incoming word is fixed here, at the moment of transfer
  always_comb begin
    load_word = s_axis_tdata;
    if (swap) begin
      load_word = {s_axis_tdata[55:48], s_axis_tdata[63:56],
                   s_axis_tdata[39:32], s_axis_tdata[47:40],
                   s_axis_tdata[23:16], s_axis_tdata[31:24],
                   s_axis_tdata[7:0],   s_axis_tdata[15:8]};
    end
  end

  // Sample presented after the current lane is consumed
  always_comb begin
    next_lane   = lane + 2'd1;
    next_sample = hold_reg[15:0];
    case (next_lane)
      2'd0:    next_sample = hold_reg[15:0];
      2'd1:    next_sample = hold_reg[31:16];
      2'd2:    next_sample = hold_reg[47:32];
      default: next_sample = hold_reg[63:48];
    endcase
  end

  // Ready is combinational on m_axis_tready so lane 3 and the next word's
  // load share a cycle and the output stream has no bubble.
  assign s_axis_tready = !areset &&
                         ((state == ST_EMPTY) ||
                          ((lane == 2'd3) && m_axis_tvalid && m_axis_tready));
  assign s_xfer = s_axis_tvalid && s_axis_tready;
  assign m_xfer = m_axis_tvalid && m_axis_tready;

  // Unpack FSM with registered output sample and valid
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_EMPTY;
      lane          <= 2'd0;
      hold_reg      <= 64'd0;
      m_axis_tdata  <= 16'd0;
      m_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (s_xfer) begin
            hold_reg      <= load_word;
            m_axis_tdata  <= load_word[15:0];
            lane          <= 2'd0;
            m_axis_tvalid <= 1'b1;
            state         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_xfer) begin
            if (lane != 2'd3) begin
              lane         <= next_lane;
              m_axis_tdata <= next_sample;
            end else if (s_xfer) begin
              hold_reg      <= load_word;
              m_axis_tdata  <= load_word[15:0];
              lane          <= 2'd0;
              m_axis_tvalid <= 1'b1;
            end else begin
              // last sample gone, nothing new: data keeps its last value
              lane          <= 2'd0;
              m_axis_tvalid <= 1'b0;
              state         <= ST_EMPTY;
            end
          end
        end
        default: begin
          state         <= ST_EMPTY;
          lane          <= 2'd0;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
  // Count every emitted sample; wraps naturally at 2^32
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sample_count <= 32'd0;
    end else if (m_xfer) begin
      sample_count <= sample_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_byteswap_unpack_64.sv
// tb_byteswap_unpack_64
// Directed vectors for byteswap_unpack_64. Inputs change on the falling
// edge; outputs are checked on the falling edge. Define
// BYTESWAP_UNPACK_SAMPLE_COUNT_EN to also check sample_count.
module tb_byteswap_unpack_64;

  logic        aclk;
  logic        areset;
  logic        swap;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
  logic [31:0] sample_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  byteswap_unpack_64 dut (
    .aclk          (aclk),
    .areset        (areset),
    .swap          (swap),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
    .m_axis_tready (m_axis_tready),
    .sample_count  (sample_count)
`else
    .m_axis_tready (m_axis_tready)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // one sample observation: valid, data, ready
  task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic r);
    chk({tag, ".tvalid"}, {63'd0, m_axis_tvalid}, {63'd0, v});
    chk({tag, ".tdata"},  {48'd0, m_axis_tdata},  {48'd0, d});
    chk({tag, ".tready"}, {63'd0, s_axis_tready}, {63'd0, r});
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  logic [15:0] exp_a [4];
  logic [15:0] exp_b [4];
  logic [15:0] exp_s [4];

  initial begin
    areset        = 1'b1;
    swap          = 1'b0;
    s_axis_tdata  = 64'd0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    exp_a = '{16'h7788, 16'h5566, 16'h3344, 16'h1122};
    exp_s = '{16'h8877, 16'h6655, 16'h4433, 16'h2211};
    exp_b = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};

    // reset state
    @(negedge aclk);
    #1;
    chk_out("rst", 1'b0, 16'h0000, 1'b0);
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
    chk("rst.count", {32'd0, sample_count}, 64'd0);
`endif
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("empty.tready", {63'd0, s_axis_tready}, 64'd1);

    // plain unpack, swap=0
    @(negedge aclk);
    swap = 1'b0;
    s_axis_tdata  = 64'h1122334455667788;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      #1;
      chk_out($sformatf("plain%0d", i), 1'b1, exp_a[i], (i == 3));
    end
    @(negedge aclk);
    #1;
    chk_out("plain.end", 1'b0, 16'h1122, 1'b1);

    // byte swap; swap flips after acceptance and must not matter
    swap = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      swap = 1'b0;
      #1;
      chk_out($sformatf("swap%0d", i), 1'b1, exp_s[i], (i == 3));
    end
    @(negedge aclk);
    #1;
    chk("swap.end.tvalid", {63'd0, m_axis_tvalid}, 64'd0);

    // back-to-back words, no bubble; counter starts from a fresh reset
    do_reset();
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
    #1;
    chk("b2b.count0", {32'd0, sample_count}, 64'd0);
`endif
    swap = 1'b0;
    s_axis_tdata  = 64'h1122334455667788;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (i == 0) s_axis_tdata = 64'h0123456789ABCDEF;
      if (i == 7) s_axis_tvalid = 1'b0;
      #1;
      chk_out($sformatf("b2b%0d", i), 1'b1,
              (i < 4) ? exp_a[i] : exp_b[i-4], ((i % 4) == 3));
    end
    @(negedge aclk);
    #1;
    chk("b2b.end.tvalid", {63'd0, m_axis_tvalid}, 64'd0);
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
    chk("b2b.count8", {32'd0, sample_count}, 64'd8);
`endif

    // backpressure at lane 1 for 5 cycles
    s_axis_tdata  = 64'h1122334455667788;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    #1;
    chk_out("bp.l0", 1'b1, 16'h7788, 1'b0);
    @(negedge aclk);
    m_axis_tready = 1'b0;
    #1;
    chk_out("bp.l1", 1'b1, 16'h5566, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (i == 4) m_axis_tready = 1'b1;
      #1;
      chk_out($sformatf("bp.stall%0d", i), 1'b1, 16'h5566, 1'b0);
    end
    @(negedge aclk);
    #1;
    chk_out("bp.l2", 1'b1, 16'h3344, 1'b0);
    @(negedge aclk);
    #1;
    chk_out("bp.l3", 1'b1, 16'h1122, 1'b1);
    @(negedge aclk);
    #1;
    chk("bp.end.tvalid", {63'd0, m_axis_tvalid}, 64'd0);

    // reset mid-word at lane 2, then a fresh word on release
    s_axis_tdata  = 64'h1122334455667788;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    #1;
    chk("mid.l2.tdata", {48'd0, m_axis_tdata}, 64'h3344);
    areset = 1'b1;
    #1;
    chk_out("mid.rst", 1'b0, 16'h0000, 1'b0);
    @(negedge aclk);
    #1;
    chk_out("mid.rst2", 1'b0, 16'h0000, 1'b0);
`ifdef BYTESWAP_UNPACK_SAMPLE_COUNT_EN
    chk("mid.count", {32'd0, sample_count}, 64'd0);
`endif
    areset = 1'b0;
    swap = 1'b0;
    s_axis_tdata  = 64'hAAAABBBBCCCCDDDD;
    s_axis_tvalid = 1'b1;
    #1;
    chk("rel.tready", {63'd0, s_axis_tready}, 64'd1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    #1;
    chk_out("rel.l0", 1'b1, 16'hDDDD, 1'b0);
    @(negedge aclk);
    #1;
    chk_out("rel.l1", 1'b1, 16'hCCCC, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byteswap_unpack_64.md
BYTESWAP_UNPACK_64 -- requirements
Module: byteswap_unpack_64

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- aclk  input  1  master clock; all state changes on its rising edge.
- areset  input  1  asynchronous, active-high reset.
- swap  input  1  1 = input words are in network byte order and are byte-swapped within each 16-bit lane; 0 = input words pass through unchanged.
- s_axis_tdata  input  64  host-to-codec word holding four 16-bit samples.
- s_axis_tvalid  input  1  input word valid.
- s_axis_tready  output  1  block can accept an input word.
- m_axis_tdata  output  16  codec sample.
- m_axis_tvalid  output  1  output sample valid.
- m_axis_tready  input  1  downstream accepts the sample.
- sample_count  output  32  number of samples emitted; present only when the Configuration macro is defined.

Function
REQ-002 Input transfer: s_axis_tvalid && s_axis_tready on a rising edge. Output transfer: m_axis_tvalid && m_axis_tready on a rising edge.
REQ-003 On an input transfer, the block SHALL store the word in a 64-bit holding register.
- swap=1: store {d[55:48],d[63:56],d[39:32],d[47:40],d[23:16],d[31:24],d[7:0],d[15:8]}.
- swap=0: store d unchanged.
- swap is sampled only at the input transfer; later changes do not alter a held word.
REQ-004 The block SHALL have two states: EMPTY and HOLD. HOLD carries a 2-bit lane index, lane 0..3.
REQ-005 EMPTY -> HOLD on an input transfer, with lane=0; m_axis_tvalid SHALL be 1 on the next cycle (latency of 1 clock).
REQ-006 In HOLD, m_axis_tdata SHALL equal holding register bits [16*lane+15:16*lane]. Lane 0 (bits [15:0]) is emitted first.
REQ-007 In HOLD, an output transfer with lane<3 SHALL increment lane. While m_axis_tready=0, m_axis_tvalid and m_axis_tdata SHALL hold stable.
REQ-008 s_axis_tready SHALL be: !areset && (state==EMPTY || (lane==3 && m_axis_tvalid && m_axis_tready)). This is a combinational path from m_axis_tready.
REQ-009 Output transfer at lane 3 with a simultaneous input transfer: load the new word, set lane=0, stay in HOLD. m_axis_tvalid SHALL remain 1, giving one sample per clock with no bubble.
REQ-010 Output transfer at lane 3 with no input transfer: go to EMPTY, with m_axis_tvalid=0 on the next cycle.
REQ-011 In EMPTY, m_axis_tvalid SHALL be 0 and m_axis_tdata SHALL hold its last value.
REQ-012 Lane index SHALL wrap 3 -> 0 only through REQ-009 or REQ-010, never by free counting.

Reset
REQ-013 While areset=1:
- state=EMPTY, lane=0
- holding register=0, m_axis_tdata=0, m_axis_tvalid=0
- s_axis_tready=0
- sample_count=0 (if present)
REQ-014 Reset asserted mid-word SHALL discard the remaining lanes. After release, the block SHALL restart in EMPTY and accept a new word on the first rising edge with s_axis_tvalid=1.

Configuration
REQ-015 Macro BYTESWAP_UNPACK_SAMPLE_COUNT_EN defined: sample_count is present. It increments by 1 on every output transfer, wraps 0xFFFFFFFF -> 0, and resets only via areset.
REQ-016 Macro undefined: the sample_count port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-017 swap=0, one word 0x1122334455667788, m_axis_tready=1 -> outputs 0x7788, 0x5566, 0x3344, 0x1122 on 4 consecutive cycles starting 1 clock after input acceptance; then m_axis_tvalid=0.
REQ-018 swap=1, same word -> outputs 0x8877, 0x6655, 0x4433, 0x2211.
REQ-019 Two words back-to-back, m_axis_tready=1, s_axis_tvalid=1 throughout -> 8 samples on 8 consecutive cycles with no gap; s_axis_tready=1 exactly on the lane-3 cycle.
REQ-020 Deassert m_axis_tready for 5 cycles at lane 1 -> m_axis_tdata holds 0x5566 with m_axis_tvalid=1; no lane skipped or repeated; s_axis_tready=0 throughout.
REQ-021 Assert areset at lane 2, then release and send 0xAAAABBBBCCCCDDDD with swap=0 -> first output is 0xDDDD; m_axis_tvalid=0 during reset.
REQ-022 With BYTESWAP_UNPACK_SAMPLE_COUNT_EN defined, after REQ-019 -> sample_count=8; after areset -> 0.
